// File: rtl/raisin64_pkg.sv
// Shared core types: architectural register geometry, register-number typedefs and a popcount helper.
package raisin64_pkg;

  localparam int NREGS = 64;
  localparam int XLEN  = 64;
  localparam int RN_W  = $clog2(NREGS);
  localparam int CNT_W = 7;

  typedef logic [RN_W-1:0] rn_t;
  typedef logic [XLEN-1:0] xword_t;

  localparam rn_t RN_ZERO = '0;
  localparam rn_t RN_LINK = rn_t'(NREGS - 1);

  function automatic logic [CNT_W-1:0] popcount(input logic [NREGS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NREGS; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: flush > commit-clear < issue-set; busy and busy_count registered (1 cycle).
// No backpressure: every write, issue and flush is accepted each cycle.
module regfile_scoreboard
  import raisin64_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [RN_W-1:0]   wr_rn,
  input  logic [1:0]        iss_valid,
  input  logic [RN_W-1:0]   iss_rn0,
  input  logic [RN_W-1:0]   iss_rn1,
  input  logic              flush,
  output logic [NREGS-1:0]  busy,
  output logic [CNT_W-1:0]  busy_count
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_nxt;
  logic [CNT_W-1:0] count_q;

  // Sets are applied after the clear so a newer producer wins over a retiring one.
  always_comb begin
    busy_nxt = busy_q;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (wr_rn != RN_ZERO) busy_nxt[wr_rn] = 1'b0;
      if (iss_valid[0] && iss_rn0 != RN_ZERO) busy_nxt[iss_rn0] = 1'b1;
      if (iss_valid[1] && iss_rn1 != RN_ZERO) busy_nxt[iss_rn1] = 1'b1;
    end
  end

  // Count is rebuilt from the vector every cycle rather than tracked incrementally.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_nxt;
      count_q <= popcount(busy_nxt);
    end
  end

  assign busy       = busy_q;
  assign busy_count = count_q;

endmodule

// File: rtl/regfile.sv
// 64x64 register file + scoreboard; reads are 0-cycle combinational, writes land at the edge.
// Never stalls. REGFILE_BYPASS_EN forwards same-cycle commit data to the read ports.
module regfile
  import raisin64_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   wr_data,
  input  logic [RN_W-1:0]   wr_rn,
  input  logic [1:0]        iss_valid,
  input  logic [RN_W-1:0]   iss_rn0,
  input  logic [RN_W-1:0]   iss_rn1,
  input  logic              flush,
  input  logic [RN_W-1:0]   rd_rn_a,
  input  logic [RN_W-1:0]   rd_rn_b,
  input  logic [RN_W-1:0]   rd_rn_c,
  input  logic [RN_W-1:0]   rd_rn_d,
  output logic [XLEN-1:0]   rd_data_a,
  output logic [XLEN-1:0]   rd_data_b,
  output logic [XLEN-1:0]   rd_data_c,
  output logic [XLEN-1:0]   rd_data_d,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  output logic              rd_busy_c,
  output logic              rd_busy_d,
  output logic [CNT_W-1:0]  busy_count
);

  xword_t           regs [NREGS];
  logic [NREGS-1:0] busy;
  rn_t              rd_rn   [4];
  xword_t           rd_data [4];
  logic             rd_busy [4];

  regfile_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .wr_rn      (wr_rn),
    .iss_valid  (iss_valid),
    .iss_rn0    (iss_rn0),
    .iss_rn1    (iss_rn1),
    .flush      (flush),
    .busy       (busy),
    .busy_count (busy_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_rn != RN_ZERO) begin
      regs[wr_rn] <= wr_data;
    end
  end

  assign rd_rn[0] = rd_rn_a;
  assign rd_rn[1] = rd_rn_b;
  assign rd_rn[2] = rd_rn_c;
  assign rd_rn[3] = rd_rn_d;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rd_data[i] = (rd_rn[i] == RN_ZERO) ? '0 : regs[rd_rn[i]];
      rd_busy[i] = busy[rd_rn[i]];
`ifdef REGFILE_BYPASS_EN
      // A forwarded operand is ready unless this same cycle re-issues a producer for it.
      if (wr_rn != RN_ZERO && rd_rn[i] == wr_rn) begin
        rd_data[i] = wr_data;
        rd_busy[i] = (iss_valid[0] && iss_rn0 == wr_rn) ||
                     (iss_valid[1] && iss_rn1 == wr_rn);
      end
`endif
    end
  end

  assign rd_data_a = rd_data[0];
  assign rd_data_b = rd_data[1];
  assign rd_data_c = rd_data[2];
  assign rd_data_d = rd_data[3];
  assign rd_busy_a = rd_busy[0];
  assign rd_busy_b = rd_busy[1];
  assign rd_busy_c = rd_busy[2];
  assign rd_busy_d = rd_busy[3];

endmodule

// File: tb/tb_regfile.sv
// Bench for regfile: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against an array-based reference model.
module tb_regfile;
  import raisin64_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [63:0]      wr_data;
  rn_t              wr_rn;
  logic [1:0]       iss_valid;
  rn_t              iss_rn0, iss_rn1;
  logic             flush;
  rn_t              rd_rn_a, rd_rn_b, rd_rn_c, rd_rn_d;
  logic [63:0]      rd_data_a, rd_data_b, rd_data_c, rd_data_d;
  logic             rd_busy_a, rd_busy_b, rd_busy_c, rd_busy_d;
  logic [6:0]       busy_count;

  regfile dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_rn(wr_rn),
    .iss_valid(iss_valid), .iss_rn0(iss_rn0), .iss_rn1(iss_rn1), .flush(flush),
    .rd_rn_a(rd_rn_a), .rd_rn_b(rd_rn_b), .rd_rn_c(rd_rn_c), .rd_rn_d(rd_rn_d),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_data_c(rd_data_c), .rd_data_d(rd_data_d),
    .rd_busy_a(rd_busy_a), .rd_busy_b(rd_busy_b), .rd_busy_c(rd_busy_c), .rd_busy_d(rd_busy_d),
    .busy_count(busy_count)
  );

  logic [63:0] m_regs [64];
  bit          m_busy [64];
  int          checks;
  int          errors;
  bit          chk_en;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 64; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic logic [63:0] exp_data(input rn_t rn);
    if (rn == 0) return 64'h0;
    if (BYP && wr_rn != 0 && rn == wr_rn) return wr_data;
    return m_regs[rn];
  endfunction

  function automatic logic [63:0] exp_busy(input rn_t rn);
    if (rn == 0) return 64'h0;
    if (BYP && wr_rn != 0 && rn == wr_rn)
      return 64'((iss_valid[0] && iss_rn0 == rn) || (iss_valid[1] && iss_rn1 == rn));
    return 64'(m_busy[rn]);
  endfunction

  // Reference state update from the current inputs, applied just before the edge.
  task automatic model_apply();
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        m_regs[i] = 64'h0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (wr_rn != 0) m_regs[wr_rn] = wr_data;
      if (flush) begin
        for (int i = 0; i < 64; i++) m_busy[i] = 1'b0;
      end else begin
        if (wr_rn != 0) m_busy[wr_rn] = 1'b0;
        if (iss_valid[0] && iss_rn0 != 0) m_busy[iss_rn0] = 1'b1;
        if (iss_valid[1] && iss_rn1 != 0) m_busy[iss_rn1] = 1'b1;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("cmp_data_a", rd_data_a, exp_data(rd_rn_a));
        chk("cmp_data_b", rd_data_b, exp_data(rd_rn_b));
        chk("cmp_data_c", rd_data_c, exp_data(rd_rn_c));
        chk("cmp_data_d", rd_data_d, exp_data(rd_rn_d));
        chk("cmp_busy_a", 64'(rd_busy_a), exp_busy(rd_rn_a));
        chk("cmp_busy_b", 64'(rd_busy_b), exp_busy(rd_rn_b));
        chk("cmp_busy_c", 64'(rd_busy_c), exp_busy(rd_rn_c));
        chk("cmp_busy_d", 64'(rd_busy_d), exp_busy(rd_rn_d));
        chk("cmp_busy_count", 64'(busy_count), 64'(m_count()));
      end
    end
  end

  task automatic idle();
    rst = 1'b0; wr_data = 64'h0; wr_rn = '0; iss_valid = 2'b00;
    iss_rn0 = '0; iss_rn1 = '0; flush = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic clk_edge();
    model_apply();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    settle();
    clk_edge();
  endtask

  initial begin
    checks = 0; errors = 0; chk_en = 1'b0;
    idle();
    rd_rn_a = '0; rd_rn_b = '0; rd_rn_c = '0; rd_rn_d = '0;
    rst = 1'b1;
    clk_edge();
    chk_en = 1'b1;
    idle();

    // Reset state across every register number.
    for (int k = 0; k < 16; k++) begin
      rd_rn_a = rn_t'(4*k); rd_rn_b = rn_t'(4*k+1); rd_rn_c = rn_t'(4*k+2); rd_rn_d = rn_t'(4*k+3);
      settle();
      chk("rst_data_a", rd_data_a, 64'h0); chk("rst_busy_a", 64'(rd_busy_a), 64'h0);
      chk("rst_data_b", rd_data_b, 64'h0); chk("rst_busy_b", 64'(rd_busy_b), 64'h0);
      chk("rst_data_c", rd_data_c, 64'h0); chk("rst_busy_c", 64'(rd_busy_c), 64'h0);
      chk("rst_data_d", rd_data_d, 64'h0); chk("rst_busy_d", 64'(rd_busy_d), 64'h0);
      chk("rst_count", 64'(busy_count), 64'h0);
      clk_edge();
    end

    // wr_rn = 0 is a no-op even with all-ones data.
    wr_rn = '0; wr_data = '1; rd_rn_a = '0;
    cycle();
    settle();
    chk("r0_reads_zero", rd_data_a, 64'h0);
    clk_edge();

    // Issue r5, commit r5 next cycle.
    idle(); iss_valid = 2'b01; iss_rn0 = 6'd5; rd_rn_a = 6'd5;
    settle();
    chk("r5_busy_before_issue", 64'(rd_busy_a), 64'h0);
    clk_edge();
    idle(); wr_rn = 6'd5; wr_data = 64'h1234;
    settle();
    chk("r5_busy_pending", 64'(rd_busy_a), BYP ? 64'h0 : 64'h1);
    chk("r5_data_commit_cycle", rd_data_a, BYP ? 64'h1234 : 64'h0);
    chk("r5_count_1", 64'(busy_count), 64'h1);
    clk_edge();
    idle();
    settle();
    chk("r5_busy_after", 64'(rd_busy_a), 64'h0);
    chk("r5_data_after", rd_data_a, 64'h1234);
    chk("r5_count_0", 64'(busy_count), 64'h0);
    clk_edge();

    // Same-cycle commit and re-issue of r7: set wins.
    idle(); iss_valid = 2'b10; iss_rn1 = 6'd7; rd_rn_a = 6'd7;
    cycle();
    idle(); wr_rn = 6'd7; wr_data = 64'h77; iss_valid = 2'b10; iss_rn1 = 6'd7;
    cycle();
    idle();
    settle();
    chk("r7_busy_waw", 64'(rd_busy_a), 64'h1);
    chk("r7_data_waw", rd_data_a, 64'h77);
    chk("r7_count_waw", 64'(busy_count), 64'h1);
    clk_edge();
    idle(); wr_rn = 6'd7; wr_data = 64'h77;
    cycle();

    // Flush beats a same-cycle issue.
    idle(); iss_valid = 2'b11; iss_rn0 = 6'd3; iss_rn1 = 6'd9;
    cycle();
    idle();
    settle();
    chk("flush_pre_count", 64'(busy_count), 64'h2);
    flush = 1'b1; iss_valid = 2'b01; iss_rn0 = 6'd12;
    clk_edge();
    idle(); rd_rn_a = 6'd12; rd_rn_b = 6'd3; rd_rn_c = 6'd9;
    settle();
    chk("flush_count", 64'(busy_count), 64'h0);
    chk("flush_r12", 64'(rd_busy_a), 64'h0);
    chk("flush_r3", 64'(rd_busy_b), 64'h0);
    chk("flush_r9", 64'(rd_busy_c), 64'h0);
    clk_edge();

    // Commit-cycle visibility of r20.
    idle(); wr_rn = 6'd20; wr_data = 64'h1111;
    cycle();
    idle(); wr_rn = 6'd20; wr_data = 64'hDEAD; rd_rn_c = 6'd20;
    settle();
    chk("r20_same_cycle", rd_data_c, BYP ? 64'hDEAD : 64'h1111);
    chk("r20_busy_same_cycle", 64'(rd_busy_c), 64'h0);
    clk_edge();
    idle();
    settle();
    chk("r20_next_cycle", rd_data_c, 64'hDEAD);
    clk_edge();

    // Reset mid-operation with ten busy registers and a write in flight.
    for (int k = 0; k < 5; k++) begin
      idle(); iss_valid = 2'b11; iss_rn0 = rn_t'(30 + 2*k); iss_rn1 = rn_t'(31 + 2*k);
      cycle();
    end
    idle();
    settle();
    chk("pre_rst_count", 64'(busy_count), 64'd10);
    rst = 1'b1; wr_rn = 6'd40; wr_data = 64'hAA; iss_valid = 2'b01; iss_rn0 = 6'd41;
    clk_edge();
    idle(); rd_rn_a = 6'd40; rd_rn_b = 6'd30; rd_rn_c = 6'd20; rd_rn_d = 6'd41;
    settle();
    chk("post_rst_count", 64'(busy_count), 64'h0);
    chk("post_rst_r40", rd_data_a, 64'h0);
    chk("post_rst_r30_busy", 64'(rd_busy_b), 64'h0);
    chk("post_rst_r20", rd_data_c, 64'h0);
    chk("post_rst_r41_busy", 64'(rd_busy_d), 64'h0);
    clk_edge();

    // Randomized traffic checked by the per-cycle compare process.
    repeat (3000) begin
      rst       = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 29) == 0);
      wr_rn     = ($urandom_range(0, 3) == 0) ? rn_t'(0) : rn_t'($urandom_range(1, 63));
      wr_data   = {$urandom, $urandom};
      iss_valid = 2'($urandom);
      iss_rn0   = ($urandom_range(0, 3) == 0) ? wr_rn : rn_t'($urandom_range(0, 63));
      iss_rn1   = ($urandom_range(0, 7) == 0) ? iss_rn0 : rn_t'($urandom_range(0, 63));
      rd_rn_a   = ($urandom_range(0, 3) == 0) ? wr_rn : rn_t'($urandom_range(0, 63));
      rd_rn_b   = rn_t'($urandom_range(0, 63));
      rd_rn_c   = ($urandom_range(0, 3) == 0) ? wr_rn : rn_t'($urandom_range(0, 63));
      rd_rn_d   = rn_t'($urandom_range(0, 63));
      cycle();
    end

    idle();
    cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
